// File: rtl/phase_pkg.sv
// Shared definitions for the phase-report frame scheduler: FSM encoding,
// frame geometry and word-forming helpers.
package phase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam int FRAME_LEN = 19;
  localparam int PH_W      = 29;
  localparam int WORD_W    = 32;
  localparam int IDX_W     = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  function automatic logic [WORD_W-1:0] zext(input logic [PH_W-1:0] v);
    return {{(WORD_W - PH_W){1'b0}}, v};
  endfunction

  function automatic logic [WORD_W-1:0] sext(input logic [PH_W-1:0] v);
    return {{(WORD_W - PH_W){v[PH_W-1]}}, v};
  endfunction

endpackage

// File: rtl/phase_frame_ser.sv
// Frame byte multiplexer and running checksum over SEQ..W4 LSB.
module phase_frame_ser
  import phase_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_clr,
  input  logic              i_acc,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [7:0]        i_seq,
  input  logic [WORD_W-1:0] i_w1,
  input  logic [WORD_W-1:0] i_w2,
  input  logic [WORD_W-1:0] i_w3,
  input  logic [WORD_W-1:0] i_w4,
  output logic [7:0]        o_byte,
  output logic [7:0]        o_chk
);

  logic [IDX_W-1:0]  k;
  logic [WORD_W-1:0] word;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    k    = i_idx - IDX_W'(2);
    word = '0;
    unique case (k[3:2])
      2'd0: word = i_w1;
      2'd1: word = i_w2;
      2'd2: word = i_w3;
      2'd3: word = i_w4;
    endcase
    o_byte = 8'h00;
    unique case (k[1:0])
      2'd0: o_byte = word[31:24];
      2'd1: o_byte = word[23:16];
      2'd2: o_byte = word[15:8];
      2'd3: o_byte = word[7:0];
    endcase
    if (i_idx == '0)                o_byte = SYNC_BYTE;
    else if (i_idx == IDX_W'(1))    o_byte = i_seq;
    else if (i_idx == LAST_IDX)     o_byte = o_chk;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      o_chk <= 8'h00;
    end else if (i_clr) begin
      o_chk <= 8'h00;
    end else if (i_acc && i_idx != '0 && i_idx != LAST_IDX) begin
      o_chk <= o_chk + o_byte;
    end
  end

endmodule

// File: rtl/phase_report_sched.sv
// Phase-result frame scheduler: latches four counter values and streams a
// 19-byte frame to a UART. Define PHASE_REPORT_DIFF_EN to send W2..W4 as
// signed differences to ph1 instead of raw values.
module phase_report_sched
  import phase_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic             i_ph_en,
  input  logic [PH_W-1:0]  i_ph1,
  input  logic [PH_W-1:0]  i_ph2,
  input  logic [PH_W-1:0]  i_ph3,
  input  logic [PH_W-1:0]  i_ph4,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [7:0]       o_drop_cnt
);

  state_t            state;
  logic [PH_W-1:0]   ph1_q, ph2_q, ph3_q, ph4_q;
  logic [WORD_W-1:0] w1, w2, w3, w4;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        seq;
  logic [7:0]        ser_byte;
  logic [7:0]        ser_chk;
  logic              acc;

  assign acc       = o_tx_valid & i_tx_ready;
  assign o_tx_data = o_tx_valid ? ser_byte : 8'h00;

`ifdef PHASE_REPORT_DIFF_EN
  logic [PH_W-1:0] d2, d3, d4;
  assign d2 = ph2_q - ph1_q;
  assign d3 = ph3_q - ph1_q;
  assign d4 = ph4_q - ph1_q;
`endif

  phase_frame_ser #(.SYNC_BYTE(SYNC_BYTE)) u_ser (
    .i_clk  (i_clk),
    .i_res  (i_res),
    .i_clr  (state == ST_LOAD),
    .i_acc  (acc),
    .i_idx  (idx),
    .i_seq  (seq),
    .i_w1   (w1),
    .i_w2   (w2),
    .i_w3   (w3),
    .i_w4   (w4),
    .o_byte (ser_byte),
    .o_chk  (ser_chk)
  );

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      state        <= ST_IDLE;
      ph1_q        <= '0;
      ph2_q        <= '0;
      ph3_q        <= '0;
      ph4_q        <= '0;
      w1           <= '0;
      w2           <= '0;
      w3           <= '0;
      w4           <= '0;
      idx          <= '0;
      seq          <= 8'h00;
      o_tx_valid   <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_drop_cnt   <= 8'h00;
    end else begin
      o_frame_done <= 1'b0;
      // Strobes outside IDLE are lost; the latched values stay untouched.
      if (i_ph_en && state != ST_IDLE && o_drop_cnt != 8'hFF)
        o_drop_cnt <= o_drop_cnt + 8'h01;

      unique case (state)
        ST_IDLE: begin
          if (i_ph_en) begin
            ph1_q  <= i_ph1;
            ph2_q  <= i_ph2;
            ph3_q  <= i_ph3;
            ph4_q  <= i_ph4;
            o_busy <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          w1 <= zext(ph1_q);
`ifdef PHASE_REPORT_DIFF_EN
          w2 <= sext(d2);
          w3 <= sext(d3);
          w4 <= sext(d4);
`else
          w2 <= zext(ph2_q);
          w3 <= zext(ph3_q);
          w4 <= zext(ph4_q);
`endif
          idx        <= '0;
          o_tx_valid <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (acc) begin
            if (idx == LAST_IDX) begin
              o_tx_valid   <= 1'b0;
              o_frame_done <= 1'b1;
              state        <= ST_DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          seq    <= seq + 8'h01;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_report_sched.sv
// Scoreboard bench for phase_report_sched: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every accepted byte.
module tb_phase_report_sched;

  logic        i_clk = 1'b0;
  logic        i_res = 1'b1;
  logic        i_ph_en = 1'b0;
  logic [28:0] i_ph1 = '0, i_ph2 = '0, i_ph3 = '0, i_ph4 = '0;
  logic        i_tx_ready = 1'b1;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_frame_done;
  logic [7:0]  o_drop_cnt;

  phase_report_sched dut (
    .i_clk        (i_clk),
    .i_res        (i_res),
    .i_ph_en      (i_ph_en),
    .i_ph1        (i_ph1),
    .i_ph2        (i_ph2),
    .i_ph3        (i_ph3),
    .i_ph4        (i_ph4),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #10 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         acc_in_frame = 0;
  bit         prev_final = 1'b0;
  logic [7:0] exp_seq = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input logic [28:0] p, input logic [28:0] r);
`ifdef PHASE_REPORT_DIFF_EN
    logic [28:0] d;
    d = p - r;
    return {{3{d[28]}}, d};
`else
    return {3'b000, p} | ({3'b000, r} & 32'h0);
`endif
  endfunction

  task automatic push(input logic [7:0] d, input bit last);
    exp_t e;
    e.data = d;
    e.last = last;
    q.push_back(e);
  endtask

  task automatic push_literal(input logic [7:0] t [19]);
    for (int i = 0; i < 19; i++) push(t[i], i == 18);
    exp_seq = exp_seq + 8'h01;
  endtask

  task automatic push_model(input logic [28:0] p1, p2, p3, p4);
    logic [31:0] w [4];
    logic [7:0]  s, b;
    w[0] = {3'b000, p1};
    w[1] = mword(p2, p1);
    w[2] = mword(p3, p1);
    w[3] = mword(p4, p1);
    push(8'hA5, 1'b0);
    push(exp_seq, 1'b0);
    s = exp_seq;
    for (int i = 0; i < 4; i++) begin
      for (int j = 3; j >= 0; j--) begin
        b = w[i][8*j +: 8];
        push(b, 1'b0);
        s = s + b;
      end
    end
    push(s, 1'b1);
    exp_seq = exp_seq + 8'h01;
  endtask

  task automatic strobe(input logic [28:0] p1, p2, p3, p4);
    i_ph1 = p1; i_ph2 = p2; i_ph3 = p3; i_ph4 = p4;
    i_ph_en = 1'b1;
    @(posedge i_clk); #1;
    i_ph_en = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge i_clk); #1;
      if (q.size() == 0 && !o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_complete", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 200; i++) begin
      if (acc_in_frame == n) break;
      @(posedge i_clk); #1;
    end
    check("reach_byte", acc_in_frame, n);
  endtask

  // Monitor: compares every accepted byte and the done pulse against the queue.
  always @(negedge i_clk) begin
    bit   fin;
    exp_t e;
    fin = 1'b0;
    if (!i_res) begin
      if (prev_final || o_frame_done)
        check("frame_done", {31'b0, o_frame_done}, {31'b0, prev_final});
      if (o_tx_valid && !i_tx_ready && q.size() > 0)
        check("hold_data", o_tx_data, q[0].data);
      if (o_tx_valid && i_tx_ready) begin
        if (q.size() == 0) begin
          check("unexpected_byte", q.size(), 1);
        end else begin
          e = q.pop_front();
          check($sformatf("byte%0d", acc_in_frame), o_tx_data, e.data);
          fin = e.last;
          acc_in_frame = e.last ? 0 : acc_in_frame + 1;
        end
      end
    end
    prev_final = fin;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] basic [19];
    logic [7:0] negw  [19];
`ifdef PHASE_REPORT_DIFF_EN
    basic = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    negw  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D};
`else
    basic = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04};
    negw  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h0F,
              8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h40};
`endif

    // Reset values
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", {31'b0, o_tx_valid}, 0);
    check("rst_busy", {31'b0, o_busy}, 0);
    check("rst_done", {31'b0, o_frame_done}, 0);
    check("rst_data", o_tx_data, 0);
    check("rst_drop", o_drop_cnt, 0);
    i_res = 1'b0;
    @(posedge i_clk); #1;

    // Basic frame with first-byte latency
    push_literal(basic);
    strobe(29'h100, 29'h100, 29'h100, 29'h100);
    check("lat_load_valid", {31'b0, o_tx_valid}, 0);
    check("lat_load_busy", {31'b0, o_busy}, 1);
    @(posedge i_clk); #1;
    check("lat_send_valid", {31'b0, o_tx_valid}, 1);
    check("lat_send_data", o_tx_data, 8'hA5);
    wait_idle();

    // Negative difference wrap
    push_literal(negw);
    strobe(29'h10, 29'h0F, 29'h10, 29'h10);
    wait_idle();

    // Backpressure on byte 7
    push_model(29'h1ABCDEF, 29'h0123456, 29'h1FFFFFF, 29'h0000001);
    strobe(29'h1ABCDEF, 29'h0123456, 29'h1FFFFFF, 29'h0000001);
    wait_acc(7);
    i_tx_ready = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      check("bp_valid", {31'b0, o_tx_valid}, 1);
    end
    @(posedge i_clk); #1;
    i_tx_ready = 1'b1;
    wait_idle();

    // Three dropped strobes during SEND
    check("drop_before", o_drop_cnt, 0);
    push_model(29'h0000ABC, 29'h0000123, 29'h1000000, 29'h0F0F0F0);
    strobe(29'h0000ABC, 29'h0000123, 29'h1000000, 29'h0F0F0F0);
    wait_acc(3);
    strobe(29'h1111111, 29'h0222222, 29'h0333333, 29'h0444444);
    strobe(29'h0555555, 29'h0666666, 29'h0777777, 29'h0888888);
    strobe(29'h0999999, 29'h0AAAAAA, 29'h0BBBBBB, 29'h0CCCCCC);
    wait_idle();
    check("drop_3", o_drop_cnt, 3);

    // 300 strobes saturate the drop counter
    push_model(29'h0000055, 29'h00000AA, 29'h0000000, 29'h1FFFFFF);
    strobe(29'h0000055, 29'h00000AA, 29'h0000000, 29'h1FFFFFF);
    i_tx_ready = 1'b0;
    i_ph_en = 1'b1;
    repeat (200) @(posedge i_clk);
    #1;
    check("drop_203", o_drop_cnt, 8'hCB);
    repeat (100) @(posedge i_clk);
    #1;
    i_ph_en = 1'b0;
    check("drop_sat", o_drop_cnt, 8'hFF);
    i_tx_ready = 1'b1;
    wait_idle();
    check("drop_sat_hold", o_drop_cnt, 8'hFF);

    // Reset at byte 10 abandons the frame
    push_model(29'h0123456, 29'h0654321, 29'h0111111, 29'h0222222);
    strobe(29'h0123456, 29'h0654321, 29'h0111111, 29'h0222222);
    wait_acc(10);
    i_res = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, o_tx_valid}, 0);
    check("mid_rst_busy", {31'b0, o_busy}, 0);
    check("mid_rst_done", {31'b0, o_frame_done}, 0);
    check("mid_rst_data", o_tx_data, 0);
    check("mid_rst_drop", o_drop_cnt, 0);
    q.delete();
    acc_in_frame = 0;
    exp_seq = 8'h00;
    @(posedge i_clk); #1;
    i_res = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      check("no_resume", {31'b0, o_tx_valid}, 0);
    end
    @(posedge i_clk); #1;

    // 257 frames: SEQ runs 00..FF then wraps back to 00
    for (int k = 0; k < 257; k++) begin
      push_model(29'(k * 3), 29'(k * 5 + 1), 29'(k), 29'(1000 - k));
      strobe(29'(k * 3), 29'(k * 5 + 1), 29'(k), 29'(1000 - k));
      wait_idle();
    end
    check("drop_after_reset", o_drop_cnt, 0);
    check("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
